// File: rtl/kv_pkg.sv
// Shared types and defaults for the key/value free-pointer pool.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kv_pkg;

  localparam int FPM_PTR_W    = 10;
  localparam int FPM_NUM_PTRS = 2 ** FPM_PTR_W;

  typedef logic [FPM_PTR_W-1:0] ptr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fpm_state_t;

  // Index width for a ring of n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/free_ptr_ring.sv
// Circular pointer store: head is read combinationally, pushes land at the tail.
// Latency: push/pop take effect on the next clk edge; head data is fall-through.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module free_ptr_ring
  import kv_pkg::*;
#(
  parameter int PTR_W    = FPM_PTR_W,
  parameter int NUM_PTRS = 2 ** PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [PTR_W-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [PTR_W-1:0] head_dat_o,
  output logic [PTR_W:0]   count_o
);

  localparam int IDX_W = idx_width(NUM_PTRS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTRS - 1);

  logic [PTR_W-1:0] mem_q [NUM_PTRS];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  assign head_dat_o = mem_q[head_q];
  assign count_o    = count_q;

  // Next-state for indices (wrap with no bubble) and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i) begin
      head_d = (head_q == LAST_IDX) ? '0 : head_q + IDX_W'(1);
    end
    if (push_i) begin
      tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + IDX_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Index and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write at the tail; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[tail_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/free_pointer_manager.sv
// Free-pointer pool: seeds 0..NUM_PTRS-1 after reset, then hands out / takes back pointers FIFO-style.
// Latency: NUM_PTRS cycles of init; allocation is fall-through, a release is offerable one cycle later.
// Backpressure: valid held stable until ready; release ready drops when the pool is full. FREE_PTR_CHECK_EN adds a double-free checker.
module free_pointer_manager
  import kv_pkg::*;
#(
  parameter int PTR_W    = FPM_PTR_W,
  parameter int NUM_PTRS = 2 ** PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PTR_W-1:0] m_free_pointer,
  output logic             m_free_pointer_valid,
  input  logic             m_free_pointer_ready,
  input  logic [PTR_W-1:0] s_release_pointer,
  input  logic             s_release_valid,
  output logic             s_release_ready,
  output logic [PTR_W:0]   free_count,
  output logic             init_done,
  output logic             double_free_err
);

  localparam int IDX_W = idx_width(NUM_PTRS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTRS - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(NUM_PTRS);

  fpm_state_t       state_q;
  logic [IDX_W-1:0] init_idx_q;
  logic             init_done_q;

  logic             init_wr;
  logic [PTR_W-1:0] init_ptr;
  logic             alloc;
  logic             rel_acc;
  logic             rel_push;
  logic             ring_push;
  logic [PTR_W-1:0] ring_push_dat;
  logic [PTR_W-1:0] head_dat;
  logic [PTR_W:0]   count;

  assign init_wr              = (state_q == INIT);
  assign m_free_pointer       = head_dat;
  assign free_count           = count;
  assign init_done            = init_done_q;
  assign m_free_pointer_valid = (state_q == RUN) && (count != '0);
  assign s_release_ready      = (state_q == RUN) && (count != FULL_CNT);
  assign alloc                = m_free_pointer_valid && m_free_pointer_ready;
  assign rel_acc              = s_release_valid && s_release_ready;

  // Zero-extend the init sequence index to a full pointer.
  always_comb begin
    init_ptr             = '0;
    init_ptr[IDX_W-1:0]  = init_idx_q;
  end

  // Pool state machine: seed one pointer per cycle, then run forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_idx_q <= init_idx_q + IDX_W'(1);
          if (init_idx_q == LAST_IDX) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef FREE_PTR_CHECK_EN
  logic [NUM_PTRS-1:0] is_free_q;
  logic                err_q;
  logic [IDX_W-1:0]    rel_idx;
  logic [IDX_W-1:0]    head_idx;
  logic                rel_drop;

  assign rel_idx         = s_release_pointer[IDX_W-1:0];
  assign head_idx        = head_dat[IDX_W-1:0];
  // Out-of-range pointers and pointers already free are swallowed.
  assign rel_drop        = ({1'b0, s_release_pointer} >= FULL_CNT) || is_free_q[rel_idx];
  assign rel_push        = rel_acc && !rel_drop;
  assign double_free_err = err_q;

  // Track which pointers sit in the pool; flag illegal releases until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_free_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (init_wr) begin
        is_free_q[init_idx_q] <= 1'b1;
      end
      if (alloc) begin
        is_free_q[head_idx] <= 1'b0;
      end
      if (rel_push) begin
        is_free_q[rel_idx] <= 1'b1;
      end
      if (rel_acc && rel_drop) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign rel_push        = rel_acc;
  assign double_free_err = 1'b0;
`endif

  assign ring_push     = init_wr || rel_push;
  assign ring_push_dat = init_wr ? init_ptr : s_release_pointer;

  free_ptr_ring #(
    .PTR_W    (PTR_W),
    .NUM_PTRS (NUM_PTRS)
  ) u_ring (
    .clk        (clk),
    .rst        (rst),
    .push_i     (ring_push),
    .push_dat_i (ring_push_dat),
    .pop_i      (alloc),
    .head_dat_o (head_dat),
    .count_o    (count)
  );

endmodule

// File: tb/tb_free_pointer_manager.sv
// Bench for free_pointer_manager at PTR_W=4, NUM_PTRS=16: directed tables, corner sequences, random vs queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_free_pointer_manager;

  localparam int PW = 4;
  localparam int NP = 16;
`ifdef FREE_PTR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] m_free_pointer;
  logic          m_free_pointer_valid;
  logic          m_free_pointer_ready;
  logic [PW-1:0] s_release_pointer;
  logic          s_release_valid;
  logic          s_release_ready;
  logic [PW:0]   free_count;
  logic          init_done;
  logic          double_free_err;

  int total = 0;
  int bad   = 0;

  free_pointer_manager #(.PTR_W(PW), .NUM_PTRS(NP)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .m_free_pointer       (m_free_pointer),
    .m_free_pointer_valid (m_free_pointer_valid),
    .m_free_pointer_ready (m_free_pointer_ready),
    .s_release_pointer    (s_release_pointer),
    .s_release_valid      (s_release_valid),
    .s_release_ready      (s_release_ready),
    .free_count           (free_count),
    .init_done            (init_done),
    .double_free_err      (double_free_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       rel_vld;
    logic [3:0] rel_ptr;
    logic       exp_vld;
    logic [3:0] exp_ptr;
    int         exp_cnt;
    logic       exp_rel_rdy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_free_pointer_ready = 1'b0;
    s_release_valid      = 1'b0;
    s_release_pointer    = '0;
  endtask

  // Reset, check the reset image, then release and count out the init phase.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    chk("rst_valid", 32'(m_free_pointer_valid), 0);
    chk("rst_rel_rdy", 32'(s_release_ready), 0);
    chk("rst_count", 32'(free_count), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_err", 32'(double_free_err), 0);
    rst = 1'b0;
    for (int i = 0; i < NP - 1; i++) tick();
    chk("init_not_done_15", 32'(init_done), 0);
    chk("init_valid_low", 32'(m_free_pointer_valid), 0);
    tick();
    chk("init_done_16", 32'(init_done), 1);
    chk("init_count", 32'(free_count), NP);
    chk("init_rel_rdy_full", 32'(s_release_ready), 0);
  endtask

  vec_t vecs[10];
  int   q[$];
  int   hist[$];
  int   prev;
  bit   merr;

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset/init, then drain the whole pool in ascending order.
    do_reset();
    m_free_pointer_ready = 1'b1;
    for (int i = 0; i < NP; i++) begin
      chk("drain_valid", 32'(m_free_pointer_valid), 1);
      chk("drain_ptr", 32'(m_free_pointer), 32'(i));
      tick();
    end
    m_free_pointer_ready = 1'b0;
    chk("drained_valid", 32'(m_free_pointer_valid), 0);
    chk("drained_count", 32'(free_count), 0);
    chk("drained_rel_rdy", 32'(s_release_ready), 1);

    // Release 7, 3 into an empty pool; then the no-bypass and hold-stable cases.
    vecs[0] = '{1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 4'd3, 1'b1, 4'd7, 1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd7, 2, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd3, 1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 1, 1'b1};
    vecs[9] = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      m_free_pointer_ready = vecs[i].rdy;
      s_release_valid      = vecs[i].rel_vld;
      s_release_pointer    = vecs[i].rel_ptr;
      chk($sformatf("vec%0d_valid", i), 32'(m_free_pointer_valid), 32'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) chk($sformatf("vec%0d_ptr", i), 32'(m_free_pointer), 32'(vecs[i].exp_ptr));
      chk($sformatf("vec%0d_count", i), 32'(free_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_rel_rdy", i), 32'(s_release_ready), 32'(vecs[i].exp_rel_rdy));
      tick();
    end
    idle_inputs();

    // Fill to 5 free, then 40 cycles of simultaneous alloc+release across the wrap.
    q.delete();
    for (int p = 10; p < 15; p++) begin
      s_release_valid   = 1'b1;
      s_release_pointer = 4'(p);
      q.push_back(p);
      tick();
    end
    chk("ss_fill_count", 32'(free_count), 5);
    prev = 15;
    m_free_pointer_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_release_valid   = 1'b1;
      s_release_pointer = 4'(prev);
      chk("ss_count", 32'(free_count), 5);
      chk("ss_ptr", 32'(m_free_pointer), 32'(q[0]));
      prev = q.pop_front();
      q.push_back(int'(s_release_pointer));
      tick();
    end
    idle_inputs();
    chk("ss_end_count", 32'(free_count), 5);
    chk("ss_end_ptr", 32'(m_free_pointer), 32'(q[0]));

    // Release a pointer that is still free.
    do_reset();
    m_free_pointer_ready = 1'b1;
    tick();
    m_free_pointer_ready = 1'b0;
    s_release_valid   = 1'b1;
    s_release_pointer = 4'd9;
    tick();
    idle_inputs();
    tick();
    chk("dbl_err", 32'(double_free_err), CHK ? 1 : 0);
    chk("dbl_count", 32'(free_count), CHK ? 15 : 16);

    // Reset mid-run with 4 free: outputs clear, pool rebuilt from 0.
    do_reset();
    m_free_pointer_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    m_free_pointer_ready = 1'b0;
    chk("pre_rst_count", 32'(free_count), 4);
    chk("pre_rst_ptr", 32'(m_free_pointer), 12);
    do_reset();
    chk("post_rst_ptr", 32'(m_free_pointer), 0);
    chk("post_rst_valid", 32'(m_free_pointer_valid), 1);

    // Random traffic against a queue model of the pool.
    q.delete();
    hist.delete();
    for (int i = 0; i < NP; i++) q.push_back(i);
    merr = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit alloc, racc, drop, inq;
      int rp;
      m_free_pointer_ready = 1'($urandom_range(0, 1));
      s_release_valid      = ($urandom_range(0, 2) != 0);
      if (hist.size() != 0 && $urandom_range(0, 9) < 8) begin
        int k;
        k  = $urandom_range(0, hist.size() - 1);
        rp = hist[k];
        if (s_release_valid && q.size() != NP) hist.delete(k);
      end else begin
        rp = $urandom_range(0, NP - 1);
      end
      s_release_pointer = 4'(rp);

      chk("rnd_valid", 32'(m_free_pointer_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rnd_ptr", 32'(m_free_pointer), 32'(q[0]));
      chk("rnd_count", 32'(free_count), 32'(q.size()));
      chk("rnd_rel_rdy", 32'(s_release_ready), 32'(q.size() != NP));
      chk("rnd_err", 32'(double_free_err), 32'(merr));

      alloc = (q.size() != 0) && m_free_pointer_ready;
      racc  = s_release_valid && (q.size() != NP);
      inq   = 1'b0;
      foreach (q[j]) if (q[j] == rp) inq = 1'b1;
      drop  = CHK && inq;
      if (alloc) hist.push_back(q.pop_front());
      if (racc && !drop) q.push_back(rp);
      if (racc && drop) merr = 1'b1;
      tick();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/free_pointer_manager.md
FREE_POINTER_MANAGER -- requirements
Module: free_pointer_manager

Interface
REQ-001 SHALL have parameter PTR_W, default 10, giving the value-buffer pointer width.
REQ-002 SHALL have parameter NUM_PTRS, default 2**PTR_W, giving the pool size; it must be a power of two and at most 2**PTR_W.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port m_free_pointer, output, PTR_W bits: pointer offered to front_end_transit's s_free_pointer.
REQ-006 SHALL have port m_free_pointer_valid, output, 1 bit: allocation offer valid.
REQ-007 SHALL have port m_free_pointer_ready, input, 1 bit: consumer takes the offered pointer.
REQ-008 SHALL have port s_release_pointer, input, PTR_W bits: pointer returned by the value store or evictor.
REQ-009 SHALL have port s_release_valid, input, 1 bit: release valid.
REQ-010 SHALL have port s_release_ready, output, 1 bit: release accepted.
REQ-011 SHALL have port free_count, output, PTR_W+1 bits: number of pointers currently free.
REQ-012 SHALL have port init_done, output, 1 bit: pool initialised.
REQ-013 SHALL have port double_free_err, output, 1 bit: sticky error flag (see Configuration).

Function
REQ-014 SHALL implement an FSM with states INIT and RUN, and enter INIT on reset.
REQ-015 In INIT, SHALL write pointers 0..NUM_PTRS-1 into a ring buffer, one per cycle, in ascending order.
REQ-016 SHALL go to RUN the cycle after pointer NUM_PTRS-1 is written; INIT therefore lasts exactly NUM_PTRS cycles.
REQ-017 In RUN, SHALL hold init_done=1 and drive free_count=NUM_PTRS at entry.
REQ-018 SHALL provide first-word-fall-through allocation: m_free_pointer_valid = (state==RUN) && (free_count!=0), and m_free_pointer = ring head.
REQ-019 SHALL count an allocation on a cycle where valid && ready; the head pointer advances and free_count decrements on the next edge.
REQ-020 SHALL drive s_release_ready = (state==RUN) && (free_count!=NUM_PTRS).
REQ-021 SHALL count a release on a cycle where valid && ready; the pointer is written at the tail and free_count increments on the next edge.
REQ-022 On simultaneous allocation and release, SHALL accept both, leave free_count unchanged and advance both head and tail.
REQ-023 SHALL keep m_free_pointer stable while valid && !ready, with no head change.
REQ-024 SHALL let head and tail indices (log2(NUM_PTRS) bits) wrap modulo NUM_PTRS with no bubble.
REQ-025 When free_count==0, a release in that cycle SHALL NOT be visible as an allocation until the next cycle (no combinational bypass).
REQ-026 SHALL NOT take any valid/ready combinationally from the opposite port's valid.

Reset
REQ-027 On rst=1 at a clk edge, SHALL set state=INIT, head=tail=0, free_count=0, init_done=0, m_free_pointer_valid=0, s_release_ready=0 and double_free_err=0.
REQ-028 On reset asserted mid-operation, SHALL discard all outstanding allocations and rebuild the pool from scratch via INIT.
REQ-029 During INIT, SHALL ignore release and allocation handshakes (both ready/valid outputs low).

Configuration
REQ-030 With macro FREE_PTR_CHECK_EN defined, SHALL keep a NUM_PTRS-bit "is free" bitmap: set in INIT, cleared on allocation, set on release.
REQ-031 With FREE_PTR_CHECK_EN defined, a release of a pointer whose bit is already 1, or >= NUM_PTRS, SHALL be accepted and dropped (no ring write, no count change) and SHALL set double_free_err until reset.
REQ-032 Without FREE_PTR_CHECK_EN, SHALL include no bitmap, write every accepted release into the ring, and tie double_free_err to 0.

Structure
REQ-033 SHALL place PTR_W and NUM_PTRS defaults, typedef ptr_t and the fpm_state_t enum {INIT, RUN} in shared package kv_pkg.
REQ-034 SHALL place the ring storage (memory, head/tail, count) in sub-module free_ptr_ring; FSM, init sequencer and checker stay in the top.

Verification (bench PTR_W=4, NUM_PTRS=16)
REQ-035 Reset then idle SHALL show init_done=1 at cycle 16 after reset release and free_count=16.
REQ-036 Ready held high for 16 cycles SHALL allocate 0,1,...,15 in order, then valid=0 and free_count=0.
REQ-037 Releasing 7 then 3 after draining SHALL allocate 7 then 3, with valid rising one cycle after release 7 is accepted.
REQ-038 Simultaneous alloc and release for 40 cycles at free_count=5 SHALL keep free_count=5 throughout, with correct FIFO order across wrap.
REQ-039 With FREE_PTR_CHECK_EN, releasing pointer 9 while free SHALL set double_free_err=1 with free_count unchanged; without the macro the flag SHALL stay 0.
REQ-040 Asserting rst with free_count=4 SHALL clear outputs next edge and, after 16 cycles, restart allocation at 0.
